sram_arbiter: RTL and testbench
===============================

Name: sram_arbiter

Overview:
- Arbitrates the external 16-bit asynchronous SRAM (18-bit address, 5-bit active-low control bus) between two requesters: port C (CPU data path) and port L (logger/DMA sampler).
- Sits inside cpu_environment and drives the addresses, control_mem and data pins directly.
- Sequences each access as a multi-cycle SRAM transaction with a one-cycle ack handshake per port.
- Supports round-robin or fixed CPU-priority arbitration.

Parameters:
ACCESS_CYCLES, 2, number of strobe cycles per access (must be >= 1)
ROUND_ROBIN, 1, 1 = alternate grants on conflict; 0 = port C always wins conflicts

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-low reset
c_req  input  1  port C request, held until c_ack
c_we  input  1  port C: 1 = write, 0 = read
c_be  input  2  port C byte enables, [1] = upper byte, [0] = lower byte
c_addr  input  18  port C word address
c_wdata  input  16  port C write data
c_rdata  output  16  port C read data, valid while c_ack = 1
c_ack  output  1  port C one-cycle completion pulse
l_req, l_we, l_be, l_addr, l_wdata, l_rdata, l_ack  (same directions, widths and meanings as port C, for port L)
addresses  output  18  SRAM address
control_mem  output  5  {ce_n, oe_n, we_n, ub_n, lb_n}, all active-low
data  inout  16  SRAM data bus, high-Z unless this block is writing
busy  output  1  1 whenever state != IDLE

Behaviour:
- Reset (reset = 0, asynchronous) forces the following immediately, with no ack issued:
  - state = IDLE
  - control_mem = 5'b11111, addresses = 0, data = Z
  - c_ack = l_ack = 0, c_rdata = l_rdata = 0, busy = 0
  - last_grant = L, so C wins the first conflict
- State IDLE:
  - No req: stay in IDLE.
  - Otherwise select a winner and latch its addr, we, be and wdata, plus the grant.
  - Go to SETUP.
- Arbitration when both requests are present:
  - ROUND_ROBIN = 1: grant the port that is not last_grant.
  - ROUND_ROBIN = 0: grant C.
  - last_grant updates on every grant.
- State SETUP (1 cycle):
  - addresses = latched addr; ce_n = 0; ub_n = ~be[1]; lb_n = ~be[0].
  - Read: oe_n = 0. Write: oe_n = 1 and data driven with wdata.
  - we_n = 1.
  - Go to STROBE.
- State STROBE (ACCESS_CYCLES cycles, down-counter):
  - Controls as in SETUP; for a write, additionally we_n = 0.
  - On the edge leaving the last STROBE cycle:
    - Read: data is sampled into the granted port's rdata register.
    - Then go to RECOVER.
- State RECOVER (1 cycle):
  - ce_n = oe_n = we_n = 1.
  - Address held; write data still driven for hold time.
  - Granted port's ack = 1; its rdata is valid (reads only; rdata is unchanged on writes).
  - Go to IDLE.
- Latency: ack is asserted ACCESS_CYCLES + 2 cycles after the edge that sampled req in IDLE (4 cycles at default).
  - Back-to-back accesses cost ACCESS_CYCLES + 3 cycles each.
- Handshake:
  - A requester keeps req, we, be, addr and wdata stable until it sees ack.
  - It deasserts req on the edge that ends the ack cycle; req still high in IDLE is a new request.
  - The non-granted port's req is ignored until the next IDLE; it is never dropped.
- Boundaries:
  - be = 2'b00: the access still runs with ub_n = lb_n = 1, and ack is issued.
  - Address 18'h3FFFF is passed through unchanged; there is no wrap logic.
  - data is never driven during a read or in IDLE, so there is no bus contention.
  - Input changes during SETUP, STROBE or RECOVER have no effect (latched copy used).
- Reset mid-operation: the access is aborted with no ack and no partial write completion guaranteed; after reset release the FSM restarts from IDLE.

Test Plan:
- Reset: hold reset = 0 -> control_mem = 5'b11111, data = Z, addresses = 0, acks = 0, busy = 0.
- Port C read, c_addr = 18'h00010, c_be = 2'b11, SRAM model returns 16'hA55A -> during SETUP/STROBE oe_n = 0, ce_n = 0, we_n = 1; c_ack pulses exactly 4 cycles after the req sample; c_rdata = 16'hA55A.
- Port L write, l_addr = 18'h3FFFF, l_wdata = 16'h1234, l_be = 2'b01 -> STROBE shows we_n = 0, ub_n = 1, lb_n = 0; data = 16'h1234 from SETUP through RECOVER; model lower byte = 8'h34, upper byte unchanged.
- Both ports request continuously with ROUND_ROBIN = 1 -> grant order C, L, C, L; each ack 5 cycles apart; no request lost.
- Both ports request continuously with ROUND_ROBIN = 0 -> C is served every time while requesting; L is granted only once C drops req.
- reset asserted during the second STROBE cycle of a write -> control_mem = 5'b11111 and data = Z immediately; no ack; after release a new C read completes normally.
- ACCESS_CYCLES = 1 build: single read -> ack exactly 3 cycles after the req sample.

Source files
------------

// File: rtl/sram_arbiter_if.sv
// Requester-side bundle for one SRAM arbiter port.
// master = requester, slave = arbiter.
interface sram_arbiter_if;
    logic        req;
    logic        we;
    logic [1:0]  be;
    logic [17:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    logic        ack;

    modport master (
        output req, we, be, addr, wdata,
        input  rdata, ack
    );

    modport slave (
        input  req, we, be, addr, wdata,
        output rdata, ack
    );
endinterface

// File: rtl/sram_arbiter.sv
// Two-port arbiter sequencing accesses to a 16-bit async SRAM.
// Each access: SETUP, ACCESS_CYCLES x STROBE, RECOVER (with ack).
module sram_arbiter #(
    parameter int unsigned ACCESS_CYCLES = 2,
    parameter bit          ROUND_ROBIN   = 1'b1
) (
    input  logic          clk,
    input  logic          reset,
    sram_arbiter_if.slave c,
    sram_arbiter_if.slave l,
    output logic [17:0]   addresses,
    output logic [4:0]    control_mem,
    inout  wire  [15:0]   data,
    output logic          busy
);

    localparam int CW = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        STROBE,
        RECOVER
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          gnt_q, gnt_d;
    logic          last_q, last_d;
    logic [17:0]   addr_q, addr_d;
    logic          we_q, we_d;
    logic [1:0]    be_q, be_d;
    logic [15:0]   wdata_q, wdata_d;
    logic [15:0]   c_rdata_q, c_rdata_d;
    logic [15:0]   l_rdata_q, l_rdata_d;

    logic pick_l;
    logic ce_n, oe_n, we_n, ub_n, lb_n;
    logic drive;

    // Grant/last_grant encoding: 1 = port L, 0 = port C.
    always_comb begin
        pick_l = l.req;
        if (c.req && l.req) begin
            pick_l = ROUND_ROBIN ? ~last_q : 1'b0;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        gnt_d     = gnt_q;
        last_d    = last_q;
        addr_d    = addr_q;
        we_d      = we_q;
        be_d      = be_q;
        wdata_d   = wdata_q;
        c_rdata_d = c_rdata_q;
        l_rdata_d = l_rdata_q;
        unique case (state_q)
            IDLE: begin
                if (c.req || l.req) begin
                    gnt_d   = pick_l;
                    last_d  = pick_l;
                    addr_d  = pick_l ? l.addr  : c.addr;
                    we_d    = pick_l ? l.we    : c.we;
                    be_d    = pick_l ? l.be    : c.be;
                    wdata_d = pick_l ? l.wdata : c.wdata;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                cnt_d   = CW'(ACCESS_CYCLES - 1);
                state_d = STROBE;
            end
            STROBE: begin
                if (cnt_q == '0) begin
                    if (!we_q) begin
                        if (gnt_q) l_rdata_d = data;
                        else       c_rdata_d = data;
                    end
                    state_d = RECOVER;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RECOVER: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            gnt_q     <= 1'b0;
            last_q    <= 1'b1;
            addr_q    <= '0;
            we_q      <= 1'b0;
            be_q      <= 2'b00;
            wdata_q   <= '0;
            c_rdata_q <= '0;
            l_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            gnt_q     <= gnt_d;
            last_q    <= last_d;
            addr_q    <= addr_d;
            we_q      <= we_d;
            be_q      <= be_d;
            wdata_q   <= wdata_d;
            c_rdata_q <= c_rdata_d;
            l_rdata_q <= l_rdata_d;
        end
    end

    // Write data stays on the bus through RECOVER for hold time.
    always_comb begin
        ce_n  = 1'b1;
        oe_n  = 1'b1;
        we_n  = 1'b1;
        ub_n  = 1'b1;
        lb_n  = 1'b1;
        drive = 1'b0;
        unique case (state_q)
            SETUP, STROBE: begin
                ce_n  = 1'b0;
                oe_n  = we_q;
                we_n  = ~(we_q && (state_q == STROBE));
                ub_n  = ~be_q[1];
                lb_n  = ~be_q[0];
                drive = we_q;
            end
            RECOVER: begin
                ub_n  = ~be_q[1];
                lb_n  = ~be_q[0];
                drive = we_q;
            end
            default: ;
        endcase
    end

    assign control_mem = {ce_n, oe_n, we_n, ub_n, lb_n};
    assign addresses   = addr_q;
    assign data        = drive ? wdata_q : 16'bz;
    assign busy        = (state_q != IDLE);

    assign c.ack   = (state_q == RECOVER) && !gnt_q;
    assign l.ack   = (state_q == RECOVER) && gnt_q;
    assign c.rdata = c_rdata_q;
    assign l.rdata = l_rdata_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: three builds (default, fixed priority,
// ACCESS_CYCLES=1), behavioural SRAMs, scoreboard and ack monitor.
module tb_sram_arbiter;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   cyc = 0;
    int   passes = 0;
    int   total = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Port index p: 0=C0 1=L0 2=C1 3=L1 4=C2 5=L2; DUT index = p/2.
    logic        req_v [6];
    logic        we_v  [6];
    logic [1:0]  be_v  [6];
    logic [17:0] addr_v[6];
    logic [15:0] wd_v  [6];
    wire  [5:0]  ack_v;
    wire  [15:0] rdata_v [6];

    wire  [4:0]  ctl_v [3];
    wire  [17:0] adr_v [3];
    wire         busy_v[3];
    wire  [15:0] dbus0, dbus1, dbus2;

    sram_arbiter_if pif [6] ();

    for (genvar g = 0; g < 6; g++) begin : g_port
        assign pif[g].req   = req_v[g];
        assign pif[g].we    = we_v[g];
        assign pif[g].be    = be_v[g];
        assign pif[g].addr  = addr_v[g];
        assign pif[g].wdata = wd_v[g];
        assign ack_v[g]     = pif[g].ack;
        assign rdata_v[g]   = pif[g].rdata;
    end

    sram_arbiter u_rr (
        .clk(clk), .reset(rst_n), .c(pif[0]), .l(pif[1]),
        .addresses(adr_v[0]), .control_mem(ctl_v[0]),
        .data(dbus0), .busy(busy_v[0])
    );

    sram_arbiter #(.ROUND_ROBIN(1'b0)) u_fp (
        .clk(clk), .reset(rst_n), .c(pif[2]), .l(pif[3]),
        .addresses(adr_v[1]), .control_mem(ctl_v[1]),
        .data(dbus1), .busy(busy_v[1])
    );

    sram_arbiter #(.ACCESS_CYCLES(1)) u_a1 (
        .clk(clk), .reset(rst_n), .c(pif[4]), .l(pif[5]),
        .addresses(adr_v[2]), .control_mem(ctl_v[2]),
        .data(dbus2), .busy(busy_v[2])
    );

    // Behavioural async SRAMs: drive on ce_n=0, oe_n=0, we_n=1.
    logic [15:0] mem [3][262144];

    assign dbus0 = (ctl_v[0][4:2] == 3'b001) ? mem[0][adr_v[0]] : 16'bz;
    assign dbus1 = (ctl_v[1][4:2] == 3'b001) ? mem[1][adr_v[1]] : 16'bz;
    assign dbus2 = (ctl_v[2][4:2] == 3'b001) ? mem[2][adr_v[2]] : 16'bz;

    function automatic logic [15:0] sram_wr(
        input logic [15:0] old, input logic [15:0] d, input logic [1:0] bn);
        return {bn[1] ? old[15:8] : d[15:8], bn[0] ? old[7:0] : d[7:0]};
    endfunction

    always @(posedge clk) begin
        if (!ctl_v[0][4] && !ctl_v[0][2])
            mem[0][adr_v[0]] = sram_wr(mem[0][adr_v[0]], dbus0, ctl_v[0][1:0]);
        if (!ctl_v[1][4] && !ctl_v[1][2])
            mem[1][adr_v[1]] = sram_wr(mem[1][adr_v[1]], dbus1, ctl_v[1][1:0]);
        if (!ctl_v[2][4] && !ctl_v[2][2])
            mem[2][adr_v[2]] = sram_wr(mem[2][adr_v[2]], dbus2, ctl_v[2][1:0]);
    end

    // Reference model: word store per DUT with byte-enable merge.
    typedef struct packed {
        logic        we;
        logic [15:0] rd;
    } exp_t;

    exp_t        expq [6][$];
    logic [15:0] refm [int];
    logic [15:0] lastrd [6];
    int          ack_port[$];
    int          ack_cyc[$];

    logic [4:0]  ctl_tr[$];
    logic [15:0] dat_tr[$];
    logic [17:0] adr_tr[$];

    function automatic logic [15:0] init_val(input logic [17:0] a);
        return a[15:0] ^ 16'h5A5A;
    endfunction

    function automatic logic [15:0] ref_rd(input int k, input logic [17:0] a);
        int key = k * 262144 + int'(a);
        if (refm.exists(key)) return refm[key];
        return init_val(a);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    always @(negedge clk) begin
        exp_t e;
        for (int p = 0; p < 6; p++) begin
            if (ack_v[p]) begin
                ack_port.push_back(p);
                ack_cyc.push_back(cyc);
                if (expq[p].size() == 0) begin
                    chk($sformatf("spurious ack p%0d", p), 32'(ack_v[p]), 32'd0);
                end else begin
                    e = expq[p].pop_front();
                    if (e.we) begin
                        chk($sformatf("rdata hold on write p%0d", p),
                            32'(rdata_v[p]), 32'(lastrd[p]));
                    end else begin
                        chk($sformatf("read data p%0d", p),
                            32'(rdata_v[p]), 32'(e.rd));
                        lastrd[p] = e.rd;
                    end
                end
            end
        end
    end

    // Issues one access, waits for ack (bounded), drops req after the ack cycle.
    task automatic access(input int p, input logic w, input logic [1:0] b,
                          input logic [17:0] a, input logic [15:0] wd,
                          output int lat);
        exp_t e;
        int   k = p / 2;
        e.we = w;
        e.rd = ref_rd(k, a);
        if (w) begin
            refm[k * 262144 + int'(a)] =
                {b[1] ? wd[15:8] : e.rd[15:8], b[0] ? wd[7:0] : e.rd[7:0]};
        end
        expq[p].push_back(e);
        we_v[p] = w; be_v[p] = b; addr_v[p] = a; wd_v[p] = wd;
        req_v[p] = 1'b1;
        ctl_tr.delete(); dat_tr.delete(); adr_tr.delete();
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            ctl_tr.push_back(ctl_v[k]);
            adr_tr.push_back(adr_v[k]);
            dat_tr.push_back(k == 0 ? dbus0 : (k == 1 ? dbus1 : dbus2));
        end while (!ack_v[p] && lat < 100);
        if (!ack_v[p]) chk($sformatf("ack timeout p%0d", p), 32'(ack_v[p]), 32'd1);
        @(posedge clk);
        #1;
        req_v[p] = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        for (int p = 0; p < 6; p++) lastrd[p] = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic rand_port(input int p, input int n, input logic [17:0] base);
        int lat;
        int g;
        for (int i = 0; i < n; i++) begin
            access(p, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                   base + 18'($urandom_range(0, 15)), 16'($urandom), lat);
            g = $urandom_range(0, 3);
            if (g > 0) begin
                repeat (g) @(posedge clk);
                #1;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        for (int p = 0; p < 6; p++) begin
            req_v[p] = 0; we_v[p] = 0; be_v[p] = 0;
            addr_v[p] = 0; wd_v[p] = 0; lastrd[p] = 0;
        end
        for (int k = 0; k < 3; k++)
            for (int a = 0; a < 262144; a++) mem[k][a] = init_val(18'(a));
        mem[0][16] = 16'hA55A;
        refm[16]   = 16'hA55A;
        mem[0][18'h100] = 16'h0F0F;

        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset control_mem", 32'(ctl_v[0]), 32'h1F);
        chk("reset addresses", 32'(adr_v[0]), 32'd0);
        chk("reset busy", 32'(busy_v[0]), 32'd0);
        chk("reset acks", 32'(ack_v), 32'd0);
        chk("reset c_rdata", 32'(rdata_v[0]), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Port C read of 0x10
        access(0, 1'b0, 2'b11, 18'h00010, 16'h0, lat);
        chk("c read latency", 32'(lat - 1), 32'd4);
        chk("idle control", 32'(ctl_tr[0]), 32'h1F);
        chk("read setup control", 32'(ctl_tr[1]), 32'b00100);
        chk("read strobe1 control", 32'(ctl_tr[2]), 32'b00100);
        chk("read strobe2 control", 32'(ctl_tr[3]), 32'b00100);
        chk("read recover ce/oe/we", 32'(ctl_tr[4][4:2]), 32'b111);
        chk("read address", 32'(adr_tr[2]), 32'h10);

        // Port L write to top address, lower byte only
        access(1, 1'b1, 2'b01, 18'h3FFFF, 16'h1234, lat);
        chk("l write latency", 32'(lat - 1), 32'd4);
        chk("write setup control", 32'(ctl_tr[1]), 32'b01110);
        chk("write strobe control", 32'(ctl_tr[2]), 32'b01010);
        chk("write strobe2 control", 32'(ctl_tr[3]), 32'b01010);
        chk("write recover ce/oe/we", 32'(ctl_tr[4][4:2]), 32'b111);
        for (int i = 1; i <= 4; i++) begin
            chk($sformatf("write data phase %0d", i), 32'(dat_tr[i]), 32'h1234);
            chk($sformatf("write addr phase %0d", i), 32'(adr_tr[i]), 32'h3FFFF);
        end
        access(1, 1'b0, 2'b11, 18'h3FFFF, 16'h0, lat);

        // be = 00 still runs and acks, memory unchanged
        access(0, 1'b1, 2'b00, 18'h00005, 16'hFFFF, lat);
        chk("be00 strobe control", 32'(ctl_tr[2]), 32'b01011);
        chk("be00 latency", 32'(lat - 1), 32'd4);
        access(0, 1'b0, 2'b11, 18'h00005, 16'h0, lat);

        // Round-robin contention
        do_reset();
        ack_port.delete(); ack_cyc.delete();
        fork
            begin
                access(0, 1'b0, 2'b11, 18'h00003, 16'h0, lat);
                access(0, 1'b1, 2'b10, 18'h00004, 16'hC0DE, lat);
            end
            begin
                access(1, 1'b1, 2'b11, 18'h3FFF2, 16'hBEAD, lat);
                access(1, 1'b0, 2'b11, 18'h3FFF2, 16'h0, lat);
            end
        join
        chk("rr ack count", 32'(ack_port.size()), 32'd4);
        if (ack_port.size() == 4) begin
            for (int i = 0; i < 4; i++)
                chk($sformatf("rr grant %0d", i), 32'(ack_port[i]), 32'(i % 2));
            for (int i = 1; i < 4; i++)
                chk($sformatf("rr spacing %0d", i),
                    32'(ack_cyc[i] - ack_cyc[i-1]), 32'd5);
        end

        // Fixed-priority contention on the second build
        ack_port.delete(); ack_cyc.delete();
        fork
            begin
                for (int i = 0; i < 3; i++)
                    access(2, 1'b0, 2'b11, 18'(i + 7), 16'h0, lat);
            end
            access(3, 1'b0, 2'b11, 18'h3FFF9, 16'h0, lat);
        join
        chk("fp ack count", 32'(ack_port.size()), 32'd4);
        if (ack_port.size() == 4) begin
            for (int i = 0; i < 4; i++)
                chk($sformatf("fp grant %0d", i), 32'(ack_port[i]),
                    32'(i < 3 ? 2 : 3));
        end

        // Reset during the second strobe cycle of a write
        we_v[0] = 1'b1; be_v[0] = 2'b11; addr_v[0] = 18'h100;
        wd_v[0] = 16'hBEEF; req_v[0] = 1'b1;
        repeat (4) @(negedge clk);
        chk("abort in strobe we_n", 32'(ctl_v[0][2]), 32'd0);
        rst_n = 1'b0;
        for (int p = 0; p < 6; p++) lastrd[p] = '0;
        #1;
        chk("abort control_mem", 32'(ctl_v[0]), 32'h1F);
        chk("abort busy", 32'(busy_v[0]), 32'd0);
        chk("abort addresses", 32'(adr_v[0]), 32'd0);
        req_v[0] = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("abort no ack", 32'(ack_v[0]), 32'd0);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("abort c_rdata cleared", 32'(rdata_v[0]), 32'd0);
        access(0, 1'b0, 2'b11, 18'h00010, 16'h0, lat);
        chk("post-abort latency", 32'(lat - 1), 32'd4);

        // ACCESS_CYCLES = 1 build
        access(4, 1'b0, 2'b11, 18'h00022, 16'h0, lat);
        chk("ac1 latency", 32'(lat - 1), 32'd3);
        chk("ac1 strobe control", 32'(ctl_tr[2]), 32'b00100);
        chk("ac1 recover ce/oe/we", 32'(ctl_tr[3][4:2]), 32'b111);

        // Randomized traffic on both ports of the default build
        fork
            rand_port(0, 20, 18'h00000);
            rand_port(1, 20, 18'h3FFF0);
        join

        repeat (10) @(negedge clk);
        for (int p = 0; p < 5; p++)
            chk($sformatf("scoreboard drained p%0d", p), 32'(expq[p].size()), 32'd0);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
